// File: rtl/cycle_event_buffer.sv
// cycle_event_buffer: turns changes of a watched counter into {value, gap} events
// queued in a show-ahead FIFO with a valid/ready drain and a saturating drop counter.
module cycle_event_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int GAP_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           cycle_count,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [WIDTH-1:0]           evt_value,
   output logic [GAP_W-1:0]           evt_gap,
   output logic [GAP_W-1:0]           drop_count,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [WIDTH-1:0] val_mem [DEPTH];
   logic [GAP_W-1:0] gap_mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [WIDTH-1:0] prev;
   logic             primed;
   logic [GAP_W-1:0] gap_ctr, gap_next;
   logic             change, pop, push, drop;
   assign evt_valid = level != '0;
   assign full      = level == LW'(DEPTH);
   assign evt_value = evt_valid ? val_mem[rd_ptr] : '0;
   assign evt_gap   = evt_valid ? gap_mem[rd_ptr] : '0;
   assign gap_next  = &gap_ctr ? gap_ctr : gap_ctr + GAP_W'(1);
   assign change    = primed && cycle_count != prev;
   assign pop       = evt_valid && evt_ready;
   // a pop frees the slot the push needs, so a full FIFO still accepts when draining
   assign push      = change && (!full || pop);
   assign drop      = change && full && !pop;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         drop_count <= '0;
         prev       <= '0;
         primed     <= 1'b0;
         gap_ctr    <= '0;
      end else begin
         if (!primed) begin
            prev    <= cycle_count;
            primed  <= 1'b1;
            gap_ctr <= '0;
         end else if (change) begin
            prev    <= cycle_count;
            gap_ctr <= '0;
         end else begin
            gap_ctr <= gap_next;
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(push) - LW'(pop);
         if (drop && !(&drop_count)) drop_count <= drop_count + GAP_W'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         val_mem[wr_ptr] <= cycle_count;
         gap_mem[wr_ptr] <= gap_next;
      end
   end
endmodule

// File: tb/tb_cycle_event_buffer.sv
// tb_cycle_event_buffer: directed and random stimulus against a queue model that
// derives gaps from absolute cycle numbers of successive changes.
module tb_cycle_event_buffer;
   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int GAP_W = 16;
   localparam int SAT   = (1 << GAP_W) - 1;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             evt_ready = 1'b0;
   logic [WIDTH-1:0] cycle_count = '0;
   logic             evt_valid, full;
   logic [WIDTH-1:0] evt_value;
   logic [GAP_W-1:0] evt_gap, drop_count;
   logic [$clog2(DEPTH):0] level;
   int errors = 0;
   int checks = 0;
   typedef struct {logic [WIDTH-1:0] v; int g;} ev_t;
   ev_t              q[$];
   logic [WIDTH-1:0] m_prev;
   bit               m_primed;
   int               m_drop, cyc, last_cyc;

   cycle_event_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
      .clk(clk), .rst(rst), .cycle_count(cycle_count), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_value(evt_value), .evt_gap(evt_gap),
      .drop_count(drop_count), .level(level), .full(full));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("evt_valid", 64'(evt_valid), 64'(q.size() != 0));
      chk("level", 64'(level), 64'(q.size()));
      chk("full", 64'(full), 64'(q.size() == DEPTH));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      if (q.size() != 0) begin
         chk("evt_value", 64'(evt_value), 64'(q[0].v));
         chk("evt_gap", 64'(evt_gap), 64'(q[0].g));
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_primed = 0;
      m_prev   = '0;
      m_drop   = 0;
   endtask

   // one clock: drive inputs, model the edge, check just after it
   task automatic step(input logic [WIDTH-1:0] v, input bit r);
      bit pop;
      int g;
      cycle_count = v;
      evt_ready   = r;
      @(posedge clk);
      cyc++;
      pop = r && q.size() != 0;
      if (pop) void'(q.pop_front());
      if (!m_primed) begin
         m_primed = 1;
         m_prev   = v;
         last_cyc = cyc;
      end else if (v != m_prev) begin
         g = cyc - last_cyc;
         if (g > SAT) g = SAT;
         if (q.size() < DEPTH) q.push_back('{v, g});
         else if (m_drop < SAT) m_drop++;
         m_prev   = v;
         last_cyc = cyc;
      end
      #1 check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      cyc++;
      #1 model_reset();
      check_all();
      chk("reset_value", 64'(evt_value), 64'(0));
      chk("reset_gap", 64'(evt_gap), 64'(0));
      rst = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] cur;
      cyc = 0;
      last_cyc = 0;
      model_reset();
      // hold a constant value: only the baseline is taken
      do_reset();
      for (int i = 0; i < 10; i++) step(5, 1'b1);
      chk("hold_level", 64'(level), 64'(0));
      // counter incrementing every cycle
      do_reset();
      step(0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         step(WIDTH'(i), 1'b1);
         chk("inc_value", 64'(evt_value), 64'(i));
         chk("inc_gap", 64'(evt_gap), 64'(1));
      end
      step(4, 1'b1);
      chk("inc_drained", 64'(level), 64'(0));
      // gap measurement and saturation
      do_reset();
      step(7, 1'b0);
      for (int i = 0; i < 3; i++) step(7, 1'b0);
      step(9, 1'b0);
      chk("gap4", 64'(evt_gap), 64'(4));
      step(9, 1'b1);
      for (int i = 0; i < 70000; i++) step(9, 1'b1);
      step(10, 1'b1);
      chk("gap_sat_value", 64'(evt_value), 64'(10));
      chk("gap_sat", 64'(evt_gap), 64'(SAT));
      step(10, 1'b1);
      // overflow with the consumer stalled, then push+pop while full
      do_reset();
      step(0, 1'b0);
      for (int i = 1; i <= 11; i++) step(WIDTH'(i), 1'b0);
      chk("ovf_full", 64'(full), 64'(1));
      chk("ovf_drops", 64'(drop_count), 64'(3));
      chk("ovf_head", 64'(evt_value), 64'(1));
      for (int i = 0; i < 3; i++) step(11, 1'b0);
      chk("stall_head", 64'(evt_value), 64'(1));
      step(12, 1'b1);
      chk("pushpop_level", 64'(level), 64'(8));
      chk("pushpop_drops", 64'(drop_count), 64'(3));
      for (int i = 0; i < 9; i++) step(12, 1'b1);
      chk("drain_empty", 64'(evt_valid), 64'(0));
      // asynchronous reset with five entries queued
      do_reset();
      step(0, 1'b0);
      for (int i = 1; i <= 5; i++) step(WIDTH'(i * 3), 1'b0);
      chk("pre_async_level", 64'(level), 64'(5));
      #2 rst = 1'b1;
      #1 model_reset();
      check_all();
      @(posedge clk);
      cyc++;
      #1 rst = 1'b0;
      step(100, 1'b0);
      step(100, 1'b0);
      step(100, 1'b0);
      step(101, 1'b0);
      chk("post_reset_gap", 64'(evt_gap), 64'(3));
      // random segments with rising consumer readiness, including wraps
      do_reset();
      cur = '1;
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 0)
               cur = ($urandom_range(0, 5) == 0) ? ((cur == '1) ? '0 : '1) : WIDTH'($urandom);
            step(cur, $urandom_range(0, 3) < s);
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
